cla_share_arb: RTL and testbench

Round-robin arbiter and sequencer that time-shares a single 16-bit carry-lookahead adder among `NREQ` requesters (ALU add/sub path, PC/branch-target add, address generation). It latches the winner's operands, drives the shared adder's A/B/Cin inputs for one execute cycle, and returns a registered sum, carry and signed overflow tagged with the winner's index. Optional saturation matches the ISA's saturating ADD/SUB semantics.

---
 rtl/cla_share_arb_if.sv | 33 +++
 rtl/cla_share_arb.sv | 123 ++++++++++++
 tb/tb_cla_share_arb.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cla_share_arb_if.sv
// Bus between the requesters/shared adder and the cla_share_arb sequencer.
// Handshake: a requester raises req[i] with stable operands and holds it until it sees gnt[i]
// (a one-cycle pulse); it drops req[i] the cycle after gnt. The result comes back as a
// one-cycle done pulse tagged with done_id, and sum/cout/ovfl hold until the next done.
interface cla_share_arb_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]      req;
    logic [16*NREQ-1:0]   op_a;
    logic [16*NREQ-1:0]   op_b;
    logic [NREQ-1:0]      op_sub;
    logic [NREQ-1:0]      gnt;
    logic [15:0]          add_a;
    logic [15:0]          add_b;
    logic                 add_cin;
    logic [15:0]          add_sum;
    logic                 add_cout;
    logic                 done;
    logic [1:0]           done_id;
    logic [15:0]          sum;
    logic                 cout;
    logic                 ovfl;

    modport master (
        output req, op_a, op_b, op_sub, add_sum, add_cout,
        input  gnt, add_a, add_b, add_cin, done, done_id, sum, cout, ovfl
    );

    modport slave (
        input  req, op_a, op_b, op_sub, add_sum, add_cout,
        output gnt, add_a, add_b, add_cin, done, done_id, sum, cout, ovfl
    );
endinterface

// File: rtl/cla_share_arb.sv
// Round-robin arbiter/sequencer sharing one 16-bit CLA adder among NREQ requesters.
// Define CLA_SAT_EN to saturate the result on signed overflow (0x7FFF / 0x8000).
module cla_share_arb #(
    parameter int NREQ = 2
) (
    input  logic              clk,
    input  logic              rst,
    cla_share_arb_if.slave    bus,
    output logic              state_dbg
);

    if (NREQ < 2 || NREQ > 4) begin : g_bad_nreq
        $error("cla_share_arb: NREQ must be 2..4");
    end

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t       state;
    logic [1:0]   last;
    logic [1:0]   cur_id;

    logic [3:0]   req_ext;
    logic [3:0]   sub_ext;
    logic [63:0]  a_ext;
    logic [63:0]  b_ext;
    logic [15:0]  a_arr [4];
    logic [15:0]  b_arr [4];

    logic         win_found;
    logic [1:0]   win_id;
    logic [1:0]   cand;

    logic         exec_ovfl;
    logic [15:0]  exec_sum;

    assign state_dbg = (state == EXEC);

    // Pad the packed requester buses to four lanes so every select is a clean 2-bit index.
    always_comb begin
        req_ext = 4'(bus.req);
        sub_ext = 4'(bus.op_sub);
        a_ext   = 64'(bus.op_a);
        b_ext   = 64'(bus.op_b);
        for (int i = 0; i < 4; i++) begin
            a_arr[i] = a_ext[16*i +: 16];
            b_arr[i] = b_ext[16*i +: 16];
        end
    end

    // Search begins one past the last winner and wraps, so the last winner has lowest priority.
    always_comb begin
        win_found = 1'b0;
        win_id    = 2'd0;
        cand      = 2'd0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = 2'((32'(last) + 32'(k)) % 32'(NREQ));
            if (!win_found && req_ext[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    // add_b already holds ~B for subtraction, so one same-sign test covers both operations.
    always_comb begin
        exec_ovfl = (bus.add_a[15] == bus.add_b[15]) && (bus.add_sum[15] != bus.add_a[15]);
`ifdef CLA_SAT_EN
        if (exec_ovfl) begin
            exec_sum = bus.add_a[15] ? 16'h8000 : 16'h7FFF;
        end else begin
            exec_sum = bus.add_sum;
        end
`else
        exec_sum = bus.add_sum;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last        <= 2'(NREQ - 1);
            cur_id      <= 2'd0;
            bus.gnt     <= '0;
            bus.add_a   <= 16'd0;
            bus.add_b   <= 16'd0;
            bus.add_cin <= 1'b0;
            bus.done    <= 1'b0;
            bus.done_id <= 2'd0;
            bus.sum     <= 16'd0;
            bus.cout    <= 1'b0;
            bus.ovfl    <= 1'b0;
        end else begin
            bus.gnt  <= '0;
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        bus.gnt     <= NREQ'(1) << win_id;
                        bus.add_a   <= a_arr[win_id];
                        bus.add_b   <= sub_ext[win_id] ? ~b_arr[win_id] : b_arr[win_id];
                        bus.add_cin <= sub_ext[win_id];
                        cur_id      <= win_id;
                        last        <= win_id;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    bus.done    <= 1'b1;
                    bus.done_id <= cur_id;
                    bus.sum     <= exec_sum;
                    bus.cout    <= bus.add_cout;
                    bus.ovfl    <= exec_ovfl;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_share_arb.sv
// Directed bench for cla_share_arb: arithmetic reference model, per-cycle compare, literal checks.
// Honours CLA_SAT_EN the same way as the design.
module tb_cla_share_arb;
    localparam int NREQ = 2;

    logic clk = 1'b0;
    logic rst;
    logic state_dbg;

    cla_share_arb_if #(.NREQ(NREQ)) bus ();

    cla_share_arb #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    // The shared carry-lookahead adder itself lives outside the arbiter.
    assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {16'd0, bus.add_cin};

    logic [15:0] tb_a [4];
    logic [15:0] tb_b [4];
    logic [3:0]  tb_sub;
    assign bus.op_a   = {tb_a[1], tb_a[0]};
    assign bus.op_b   = {tb_b[1], tb_b[0]};
    assign bus.op_sub = tb_sub[1:0];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Signed/unsigned integer arithmetic: returns {ovfl, cout, sum}.
    function automatic logic [17:0] op_model(input logic [15:0] a, input logic [15:0] b, input logic sub);
        int          sa, sb, r, ua, ub;
        logic        c, ov;
        logic [15:0] s;
        sa = int'($signed(a));
        sb = int'($signed(b));
        ua = int'(a);
        ub = int'(b);
        r  = sub ? sa - sb : sa + sb;
        c  = sub ? (ua >= ub) : ((ua + ub) > 65535);
        ov = (r > 32767) || (r < -32768);
        s  = 16'(r);
`ifdef CLA_SAT_EN
        if (ov) s = (r > 0) ? 16'h7FFF : 16'h8000;
`endif
        return {ov, c, s};
    endfunction

    // First requester after 'last' in circular order: returns {found, index}.
    function automatic logic [2:0] rr_pick(input logic [NREQ-1:0] r, input logic [1:0] last);
        logic [3:0] r4;
        logic [1:0] i;
        r4 = 4'(r);
        for (int k = 1; k <= NREQ; k++) begin
            i = 2'((int'(last) + k) % NREQ);
            if (r4[i]) return {1'b1, i};
        end
        return 3'b000;
    endfunction

    logic            m_ok = 1'b0;
    logic            m_busy;
    logic [1:0]      m_last, m_id, p_id;
    logic [NREQ-1:0] m_gnt;
    logic            m_done, m_cout, m_ovfl, p_cout, p_ovfl, m_add_cin;
    logic [15:0]     m_sum, p_sum, m_add_a, m_add_b;
    logic [2:0]      m_pick;
    logic [15:0]     m_a, m_b;
    logic            m_s;

    assign m_pick = rr_pick(bus.req, m_last);
    assign m_a    = tb_a[m_pick[1:0]];
    assign m_b    = tb_b[m_pick[1:0]];
    assign m_s    = tb_sub[m_pick[1:0]];

    always @(posedge clk) begin
        if (rst) begin
            m_ok      <= 1'b1;
            m_busy    <= 1'b0;
            m_last    <= 2'(NREQ - 1);
            m_gnt     <= '0;
            m_done    <= 1'b0;
            m_id      <= 2'd0;
            m_sum     <= 16'd0;
            m_cout    <= 1'b0;
            m_ovfl    <= 1'b0;
            m_add_a   <= 16'd0;
            m_add_b   <= 16'd0;
            m_add_cin <= 1'b0;
        end else if (!m_busy) begin
            m_done <= 1'b0;
            if (m_pick[2]) begin
                m_gnt                    <= NREQ'(1) << m_pick[1:0];
                m_busy                   <= 1'b1;
                m_last                   <= m_pick[1:0];
                p_id                     <= m_pick[1:0];
                {p_ovfl, p_cout, p_sum}  <= op_model(m_a, m_b, m_s);
                m_add_a                  <= m_a;
                m_add_b                  <= m_s ? ~m_b : m_b;
                m_add_cin                <= m_s;
            end else begin
                m_gnt <= '0;
            end
        end else begin
            m_gnt  <= '0;
            m_done <= 1'b1;
            m_id   <= p_id;
            m_sum  <= p_sum;
            m_cout <= p_cout;
            m_ovfl <= p_ovfl;
            m_busy <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("cyc_gnt",     32'(bus.gnt),     32'(m_gnt));
            chk("cyc_done",    32'(bus.done),    32'(m_done));
            chk("cyc_done_id", 32'(bus.done_id), 32'(m_id));
            chk("cyc_sum",     32'(bus.sum),     32'(m_sum));
            chk("cyc_cout",    32'(bus.cout),    32'(m_cout));
            chk("cyc_ovfl",    32'(bus.ovfl),    32'(m_ovfl));
            chk("cyc_add_a",   32'(bus.add_a),   32'(m_add_a));
            chk("cyc_add_b",   32'(bus.add_b),   32'(m_add_b));
            chk("cyc_add_cin", 32'(bus.add_cin), 32'(m_add_cin));
            chk("cyc_state",   32'(state_dbg),   32'(m_busy));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input string name, input logic [1:0] idx, input logic [15:0] a,
                         input logic [15:0] b, input logic sub, input logic [15:0] es,
                         input logic ec, input logic eo);
        tb_a[idx]   = a;
        tb_b[idx]   = b;
        tb_sub[idx] = sub;
        bus.req     = bus.req | (NREQ'(1) << idx);
        tick();
        chk({name, "_gnt"}, 32'(bus.gnt), 32'(NREQ'(1) << idx));
        bus.req = '0;
        tick();
        chk({name, "_done"},    32'(bus.done),    32'd1);
        chk({name, "_sum"},     32'(bus.sum),     32'(es));
        chk({name, "_cout"},    32'(bus.cout),    32'(ec));
        chk({name, "_ovfl"},    32'(bus.ovfl),    32'(eo));
        chk({name, "_done_id"}, 32'(bus.done_id), 32'(idx));
    endtask

    logic [1:0]  fair_gnt [8];
    logic [1:0]  fair_id  [8];
    logic [15:0] fair_sum [8];

    initial begin
        rst     = 1'b1;
        bus.req = '0;
        tb_sub  = 4'd0;
        for (int i = 0; i < 4; i++) begin
            tb_a[i] = 16'd0;
            tb_b[i] = 16'd0;
        end
        fair_gnt = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        fair_id  = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1};
        fair_sum = '{16'h0, 16'h2, 16'h2, 16'h3, 16'h3, 16'h2, 16'h2, 16'h3};

        repeat (2) tick();
        chk("rst_gnt",   32'(bus.gnt),   32'd0);
        chk("rst_done",  32'(bus.done),  32'd0);
        chk("rst_sum",   32'(bus.sum),   32'd0);
        chk("rst_add_a", 32'(bus.add_a), 32'd0);
        chk("rst_add_b", 32'(bus.add_b), 32'd0);
        chk("rst_cin",   32'(bus.add_cin), 32'd0);
        rst = 1'b0;

        do_op("add",    2'd0, 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);
        do_op("borrow", 2'd1, 16'h0001, 16'h0002, 1'b1, 16'hFFFF, 1'b0, 1'b0);
`ifdef CLA_SAT_EN
        do_op("ovf_add", 2'd0, 16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        do_op("ovf_sub", 2'd1, 16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1, 1'b1);
`else
        do_op("ovf_add", 2'd0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op("ovf_sub", 2'd1, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif

        // Both requesters held from reset: 1+1 for requester 0, 5-2 for requester 1.
        rst       = 1'b1;
        tb_a[0]   = 16'h0001; tb_b[0] = 16'h0001; tb_sub[0] = 1'b0;
        tb_a[1]   = 16'h0005; tb_b[1] = 16'h0002; tb_sub[1] = 1'b1;
        bus.req   = '1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("fair_gnt", 32'(bus.gnt), 32'(fair_gnt[i]));
            if (i % 2 == 1) begin
                chk("fair_done",    32'(bus.done),    32'd1);
                chk("fair_done_id", 32'(bus.done_id), 32'(fair_id[i]));
                chk("fair_sum",     32'(bus.sum),     32'(fair_sum[i]));
            end
        end
        bus.req = '0;
        repeat (2) tick();

        // Back-to-back: a new request in the done cycle is granted on the next edge.
        tb_a[0] = 16'h0010; tb_b[0] = 16'h0020; tb_sub[0] = 1'b0;
        bus.req = 2'b01;
        tick();
        chk("b2b_gnt1", 32'(bus.gnt), 32'h1);
        bus.req = '0;
        tick();
        chk("b2b_done1", 32'(bus.done), 32'd1);
        chk("b2b_sum1",  32'(bus.sum),  32'h0030);
        tb_a[0] = 16'h0064; tb_b[0] = 16'h0001; tb_sub[0] = 1'b1;
        bus.req = 2'b01;
        tick();
        chk("b2b_gnt2",  32'(bus.gnt),  32'h1);
        chk("b2b_hold",  32'(bus.sum),  32'h0030);
        chk("b2b_nodone", 32'(bus.done), 32'd0);
        bus.req = '0;
        tick();
        chk("b2b_done2", 32'(bus.done), 32'd1);
        chk("b2b_sum2",  32'(bus.sum),  32'h0063);
        chk("b2b_cout2", 32'(bus.cout), 32'd1);

        // Reset while in EXEC discards the operation and restores priority to requester 0.
        tb_a[0] = 16'h1234; tb_b[0] = 16'h1111; tb_sub[0] = 1'b0;
        tb_a[1] = 16'h4321; tb_b[1] = 16'h0021; tb_sub[1] = 1'b1;
        bus.req = '1;
        tick();
        chk("mid_gnt", 32'(bus.gnt), 32'h2);
        rst = 1'b1;
        tick();
        chk("mid_done",    32'(bus.done),    32'd0);
        chk("mid_sum",     32'(bus.sum),     32'd0);
        chk("mid_gnt0",    32'(bus.gnt),     32'd0);
        chk("mid_add_a",   32'(bus.add_a),   32'd0);
        chk("mid_done_id", 32'(bus.done_id), 32'd0);
        chk("mid_ovfl",    32'(bus.ovfl),    32'd0);
        rst = 1'b0;
        tick();
        chk("mid_regrant", 32'(bus.gnt), 32'h1);
        bus.req = '0;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
